// File: rtl/dmem_if.sv
// Request/acknowledge bus between the core datapath and the data memory.
// The master presents req/we/addr/wdata; the slave returns ack/rdata/busy.
interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata,
    input  busy
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata,
    output busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM responder with a programmable number of wait
// states between request capture and the one-cycle ack pulse.
module dmem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_we;
  logic              load_fire;
  logic              mem_we;

  // With zero wait states RESP is entered straight from IDLE, before the
  // request has been latched, so the read must use the live bus fields.
  assign rd_addr = (state_q == S_IDLE) ? bus.addr : addr_q;
  assign rd_we   = (state_q == S_IDLE) ? bus.we   : we_q;

  assign load_fire = (state_d == S_RESP) &&
                     (state_q != S_RESP) &&
                     !rd_we;

  assign mem_we = (state_q == S_RESP) && we_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          we_d    = bus.we;
          wdata_d = bus.wdata;
          cnt_d   = WAIT_C;
          state_d = (WAIT_C == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (load_fire) begin
      rdata_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The array keeps its contents across reset; a reset during RESP forces
  // IDLE before the next edge, so a pending store is dropped.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign bus.ack   = (state_q == S_RESP);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT = 2, 0, 4) checked
// against a per-instance array model of memory contents and rdata.
module tb_dmem_responder;

  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic          req   [3];
  logic          we    [3];
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];
  logic          ack   [3];
  logic [DW-1:0] rdata [3];
  logic          busy  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    assign bus.req   = req[g];
    assign bus.we    = we[g];
    assign bus.addr  = addr[g];
    assign bus.wdata = wdata[g];
    assign ack[g]    = bus.ack;
    assign rdata[g]  = bus.rdata;
    assign busy[g]   = bus.busy;
    dmem_responder #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .WAIT  (g == 0 ? 2 : (g == 1 ? 0 : 4))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  int errs   = 0;
  int checks = 0;

  logic [DW-1:0] mem_m [3][256];
  bit            wr_m  [3][256];
  logic [DW-1:0] rd_m  [3];

  function automatic int wait_of(input int s);
    return (s == 0) ? 2 : ((s == 1) ? 0 : 4);
  endfunction

  task automatic txn(input int s, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input string tag);
    int n;
    int nb;
    bit got;
    @(negedge clk);
    req[s] = 1'b1;
    we[s] = w;
    addr[s] = a;
    wdata[s] = d;
    n = 0;
    nb = 0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (busy[s] === 1'b1) nb++;
      if (ack[s] === 1'b1) got = 1;
    end
    req[s] = 1'b0;
    checks++;
    if (!got) begin
      errs++;
      $display("FAIL %s timeout: no ack within %0d cycles", tag, n);
      return;
    end
    checks++;
    if (n !== wait_of(s) + 1) begin
      errs++;
      $display("FAIL %s latency: got %0d want %0d", tag, n, wait_of(s) + 1);
    end
    checks++;
    if (nb !== wait_of(s) + 1) begin
      errs++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, nb,
               wait_of(s) + 1);
    end
    if (!w) begin
      rd_m[s] = mem_m[s][a];
      checks++;
      if (rdata[s] !== rd_m[s]) begin
        errs++;
        $display("FAIL %s rdata@ack: got %h want %h", tag, rdata[s], rd_m[s]);
      end
    end else begin
      mem_m[s][a] = d;
      wr_m[s][a] = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (ack[s] !== 1'b0 || busy[s] !== 1'b0) begin
      errs++;
      $display("FAIL %s post_ack: ack=%b busy=%b want 0/0", tag, ack[s],
               busy[s]);
    end
    checks++;
    if (rdata[s] !== rd_m[s]) begin
      errs++;
      $display("FAIL %s rdata_hold: got %h want %h", tag, rdata[s], rd_m[s]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      req[s] = 1'b0;
      we[s] = 1'b0;
      addr[s] = '0;
      wdata[s] = '0;
      rd_m[s] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        checks++;
        if (ack[s] !== 1'b0 || busy[s] !== 1'b0 || rdata[s] !== '0) begin
          errs++;
          $display("FAIL reset_idle[%0d]: ack=%b busy=%b rdata=%h want 0",
                   s, ack[s], busy[s], rdata[s]);
        end
      end
    end
  endtask

  task automatic test_store_load();
    txn(0, 1'b1, 8'h10, 32'hDEADBEEF, "w2_store");
    txn(0, 1'b0, 8'h10, 32'h0, "w2_load");
    repeat (3) @(negedge clk);
    checks++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL w2_hold: got %h want deadbeef", rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic        ops_we [6];
    logic [31:0] ops_d  [6];
    int  k;
    int  n;
    int  last;
    bit  prev;
    for (int i = 0; i < 6; i++) begin
      ops_we[i] = (i % 2 == 0);
      ops_d[i] = (i < 2) ? 32'h1 : $urandom;
    end
    @(negedge clk);
    req[1] = 1'b1;
    we[1] = ops_we[0];
    addr[1] = 8'h05;
    wdata[1] = ops_d[0];
    k = 0;
    n = 0;
    last = 0;
    prev = 0;
    while (k < 6 && n < 60) begin
      @(negedge clk);
      n++;
      if (ack[1] === 1'b1) begin
        checks++;
        if (prev) begin
          errs++;
          $display("FAIL b2b_double_ack: ack high two cycles at op %0d", k);
        end
        checks++;
        if (n - last !== ((k == 0) ? 1 : 2)) begin
          errs++;
          $display("FAIL b2b_spacing op %0d: got %0d want %0d", k, n - last,
                   (k == 0) ? 1 : 2);
        end
        last = n;
        if (ops_we[k]) begin
          mem_m[1][5] = ops_d[k];
          wr_m[1][5] = 1'b1;
        end else begin
          rd_m[1] = mem_m[1][5];
          checks++;
          if (rdata[1] !== rd_m[1]) begin
            errs++;
            $display("FAIL b2b_rdata op %0d: got %h want %h", k, rdata[1],
                     rd_m[1]);
          end
        end
        k++;
        if (k < 6) begin
          we[1] = ops_we[k];
          wdata[1] = ops_d[k];
        end else begin
          req[1] = 1'b0;
        end
      end
      prev = (ack[1] === 1'b1);
    end
    req[1] = 1'b0;
    checks++;
    if (k !== 6) begin
      errs++;
      $display("FAIL b2b_count: got %0d acks want 6", k);
    end
    @(negedge clk);
    checks++;
    if (ack[1] !== 1'b0) begin
      errs++;
      $display("FAIL b2b_tail_ack: got %b want 0", ack[1]);
    end
  endtask

  task automatic test_wait_ignore();
    int  n;
    bit  got;
    txn(0, 1'b1, 8'hFF, 32'hCAFEF00D, "ign_pre");
    @(negedge clk);
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[0] = 8'h20;
    wdata[0] = 32'h12345678;
    @(negedge clk);
    addr[0] = 8'hFF;
    wdata[0] = 32'h0;
    n = 1;
    got = (ack[0] === 1'b1);
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = (ack[0] === 1'b1);
    end
    req[0] = 1'b0;
    checks++;
    if (!got || n !== 3) begin
      errs++;
      $display("FAIL ign_latency: got %0d (ack seen %0d) want 3", n, got);
    end
    mem_m[0][8'h20] = 32'h12345678;
    wr_m[0][8'h20] = 1'b1;
    @(negedge clk);
    txn(0, 1'b0, 8'h20, 32'h0, "ign_load20");
    txn(0, 1'b0, 8'hFF, 32'h0, "ign_loadFF");
  endtask

  task automatic test_reset_mid();
    txn(0, 1'b1, 8'h30, 32'h0, "rst_pre");
    txn(0, 1'b0, 8'hFF, 32'h0, "rst_prime");
    @(negedge clk);
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[0] = 8'h30;
    wdata[0] = 32'hAAAA5555;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errs++;
      $display("FAIL rst_inwait_busy: got %b want 1", busy[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || ack[0] !== 1'b0 || rdata[0] !== '0) begin
      errs++;
      $display("FAIL rst_async: busy=%b ack=%b rdata=%h want 0", busy[0],
               ack[0], rdata[0]);
    end
    req[0] = 1'b0;
    for (int s = 0; s < 3; s++) rd_m[s] = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
        errs++;
        $display("FAIL rst_hold: ack=%b busy=%b want 0", ack[0], busy[0]);
      end
    end
    rst = 1'b0;
    txn(0, 1'b0, 8'h30, 32'h0, "rst_load30");
  endtask

  task automatic test_wait4();
    txn(2, 1'b1, 8'h07, $urandom, "w4_pre");
    txn(2, 1'b0, 8'h07, 32'h0, "w4_load_old");
    txn(2, 1'b1, 8'h07, $urandom, "w4_store");
    txn(2, 1'b0, 8'h07, 32'h0, "w4_load_new");
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) begin
        txn(s, 1'b1, 8'h40 + 8'(i), $urandom, "rnd_init");
      end
      for (int i = 0; i < 24; i++) begin
        a = 8'h40 + 8'($urandom_range(0, 7));
        txn(s, 1'($urandom_range(0, 1)), a, $urandom, "rnd_op");
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_wait_ignore();
    test_reset_mid();
    test_wait4();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
